dual_port_ram_param: RTL
========================

Name: dual_port_ram_param

Overview:
Parametrised simple dual-port RAM: one write port and one independent read port on a single clock.
- Per-byte write enables.
- Configurable read latency with a read-valid strobe.
- Hardware clear sweep that zeroes memory after reset or on request, with a busy flag.
- Storage for datapath buffers; replaces the fixed 16x8 RAMs.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of 8; BE_W = DATA_W/8 (derived).
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words (derived).
RD_LAT, 1, read latency in cycles; legal values 1 or 2; others are a compile-time error.

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous request to start a clear sweep
we  input  1  write enable
be  input  BE_W  byte-lane write enables; bit k covers din[8k+7:8k]
wr_addr  input  ADDR_W  write address
din  input  DATA_W  write data
re  input  1  read enable
rd_addr  input  ADDR_W  read address
dout  output  DATA_W  read data (registered)
rd_valid  output  1  one-cycle pulse: dout updated this cycle
busy  output  1  clear sweep in progress; requests ignored
req_drop  output  1  one-cycle pulse: a we or re was ignored because busy

Behaviour:
- Reset: rst is asynchronous and active-high.
  - rst asserted: dout=0, rd_valid=0, req_drop=0, busy=1, read pipeline flushed, FSM=CLEAR, clr_cnt=0.
  - Memory array is not reset asynchronously; it is cleared by the sweep.
- FSM states:
  - CLEAR: each posedge writes 0 to mem[clr_cnt], then clr_cnt increments. After writing index DEPTH-1, go to READY. Total DEPTH cycles after rst deasserts. busy=1 throughout.
  - READY: busy=0. clr=1 sampled high enters CLEAR with clr_cnt=0; busy rises the next cycle.
- Sweep rules:
  - clr is ignored while already in CLEAR; the sweep does not restart.
  - rst asserted mid-sweep restarts the sweep from index 0.
- Requests while busy:
  - we and re are ignored; memory and dout are unchanged.
  - req_drop pulses 1 cycle after any cycle with busy=1 and (we|re)=1.
  - A we or re in the same cycle that clr is sampled in READY is still performed. The sweep starts next cycle and overwrites it.
- Write: in READY with we=1, at posedge update mem[wr_addr] lane k iff be[k]=1. we=1 with be=0 is a legal no-op.
- Read: in READY with re=1, sample rd_addr.
  - dout holds mem[rd_addr] and rd_valid=1 exactly RD_LAT cycles later.
  - Back-to-back reads give one result per cycle.
  - dout holds its last value when rd_valid=0.
- Pipeline: reads in flight when the FSM enters CLEAR via clr still complete and deliver pre-clear data.
- Collision (we and re same cycle, wr_addr==rd_addr): read-first by default; returns the old word.
- Different addresses: fully independent; no stalls.
- Addresses wrap naturally; all ADDR_W values are valid.

Optional Feature:
RAM_WR_BYPASS_EN
- Defined: on a same-address, same-cycle collision, the read returns the merged word. Lanes with be[k]=1 take din; others take the old memory value. This is write-first behaviour.
- Also defined: for RD_LAT=2, a write to the address of a read in its second stage does not affect that read.
- Undefined: read-first as above; no bypass mux is present.

Test Plan:
- Reset and sweep: pulse rst mid-run, hold re=1. Required:
  - busy=1 for exactly 16 cycles after deassert (defaults).
  - req_drop pulses each busy cycle.
  - After READY, reads of all 16 addresses return 8'h00 with rd_valid.
- Fill and readback: write addr i with data i*17+3 for i=0..15, be=1, then read 0..15 back-to-back. Required: dout sequence matches, rd_valid high 16 consecutive cycles, at latency RD_LAT for 1 and 2.
- Byte enables: DATA_W=32, write 32'hAABBCCDD to addr 5, then write 32'h11223344 with be=4'b0101. Required: readback 32'hAA22CC44.
- Collision, same addr 3 (old 8'h5A, write 8'hC3 with re=1). Required: without macro dout=8'h5A, then next read 8'hC3; with RAM_WR_BYPASS_EN dout=8'hC3.
- Clear request mid-traffic: write addr 7=8'h99, issue re on addr 7 and clr in the same cycle. Required:
  - Read delivers 8'h99.
  - busy high for DEPTH cycles.
  - Subsequent read of addr 7 returns 8'h00.
  - clr re-pulsed during the sweep does not extend busy.
- Async reset during read pipeline (RD_LAT=2): assert rst between clk edges with a read in flight. Required: dout=0 and rd_valid=0 immediately, without waiting for a clock edge, and no stale rd_valid after release.

Source files
------------

// File: rtl/dual_port_ram_param.sv
// Simple dual-port RAM (one write port, one read port, single clock) with byte enables,
// RD_LAT 1/2 read pipeline and hardware clear sweep. Optional macro: RAM_WR_BYPASS_EN.
module dual_port_ram_param #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  we,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     din,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     dout,
   output logic                  rd_valid,
   output logic                  busy,
   output logic                  req_drop
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_width
      $error("dual_port_ram_param: DATA_W must be a non-zero multiple of 8");
   end

   typedef enum logic {CLEAR, READY} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   clr_cnt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rd_word;
   logic                wr_acc;
   logic                rd_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
         else                clr_cnt <= '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_cnt == '1) state_nxt = READY;
         READY:   if (clr)           state_nxt = CLEAR;
         default: state_nxt = CLEAR;
      endcase
   end

   always_comb begin
      busy   = (state == CLEAR);
      wr_acc = (state == READY) && we;
      rd_acc = (state == READY) && re;
   end

   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clr_cnt] <= '0;
      end else if (we) begin
         for (int unsigned k = 0; k < BE_W; k++) begin
            if (be[k]) mem[wr_addr][8*k +: 8] <= din[8*k +: 8];
         end
      end
   end

`ifdef RAM_WR_BYPASS_EN
   // Same-cycle same-address write is merged lane by lane into the read word.
   always_comb begin
      rd_word = mem[rd_addr];
      if (wr_acc && (wr_addr == rd_addr)) begin
         for (int unsigned k = 0; k < BE_W; k++) begin
            if (be[k]) rd_word[8*k +: 8] = din[8*k +: 8];
         end
      end
   end
`else
   always_comb begin
      rd_word = mem[rd_addr];
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) req_drop <= 1'b0;
      else     req_drop <= busy && (we || re);
   end

   if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout     <= '0;
            rd_valid <= 1'b0;
         end else begin
            rd_valid <= rd_acc;
            if (rd_acc) dout <= rd_word;
         end
      end
   end else if (RD_LAT == 2) begin : g_lat2
      logic              p1_v;
      logic [DATA_W-1:0] p1_data;

      // Data is captured in stage 1, so later writes or a clear sweep cannot alter it.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            p1_v     <= 1'b0;
            p1_data  <= '0;
            dout     <= '0;
            rd_valid <= 1'b0;
         end else begin
            p1_v     <= rd_acc;
            if (rd_acc) p1_data <= rd_word;
            rd_valid <= p1_v;
            if (p1_v) dout <= p1_data;
         end
      end
   end else begin : g_bad_lat
      $error("dual_port_ram_param: RD_LAT must be 1 or 2");
   end

endmodule
